// File: rtl/oam_dma_controller.sv
// Sprite DMA engine: a write to $4014 halts the CPU and copies one 256-byte page to $2004.
// All bus-facing outputs are registered; each is loaded alongside the state it belongs to.
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        cpu_clock,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic        cpu_write_n,
  input  logic [7:0]  cpu_data_out,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] dma_address,
  output logic        dma_read_n,
  output logic        dma_write_n,
  input  logic [7:0]  dma_data_in,
  output logic [7:0]  dma_data_out,
  output logic [7:0]  OAMDMA_reg,
  output logic [7:0]  OAMDMA_reg_active
);

  typedef enum logic [2:0] {StIdle, StHalt, StAlign, StRead, StWrite} state_e;

  state_e      state_q;
  logic        parity_q;
  logic [7:0]  index_q;
  logic [7:0]  buffer_q;
  logic [7:0]  page_q;
  logic        cpu_rdy_q;
  logic        dma_active_q;
  logic        read_n_q;
  logic        write_n_q;
  logic [15:0] address_q;

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      state_q      <= StIdle;
      parity_q     <= 1'b0;
      index_q      <= 8'h00;
      buffer_q     <= 8'h00;
      page_q       <= 8'h00;
      cpu_rdy_q    <= 1'b1;
      dma_active_q <= 1'b0;
      read_n_q     <= 1'b1;
      write_n_q    <= 1'b1;
      address_q    <= 16'h0000;
    end else begin
      parity_q <= ~parity_q;
      unique case (state_q)
        StIdle: begin
          if (!cpu_write_n && (cpu_address == DMA_REG_ADDR)) begin
            page_q       <= cpu_data_out;
            index_q      <= 8'h00;
            cpu_rdy_q    <= 1'b0;
            dma_active_q <= 1'b1;
            state_q      <= StHalt;
          end
        end
        StHalt: begin
          // Reads must land on parity 0; an odd halt cycle goes straight to READ.
          if (parity_q) begin
            state_q   <= StRead;
            read_n_q  <= 1'b0;
            address_q <= {page_q, index_q};
          end else begin
            state_q <= StAlign;
          end
        end
        StAlign: begin
          state_q   <= StRead;
          read_n_q  <= 1'b0;
          address_q <= {page_q, index_q};
        end
        StRead: begin
          buffer_q  <= dma_data_in;
          state_q   <= StWrite;
          read_n_q  <= 1'b1;
          write_n_q <= 1'b0;
          address_q <= OAM_DATA_ADDR;
        end
        StWrite: begin
          write_n_q <= 1'b1;
          if (index_q == 8'hFF) begin
            state_q      <= StIdle;
            cpu_rdy_q    <= 1'b1;
            dma_active_q <= 1'b0;
            address_q    <= 16'h0000;
          end else begin
            index_q   <= index_q + 8'd1;
            state_q   <= StRead;
            read_n_q  <= 1'b0;
            address_q <= {page_q, index_q + 8'd1};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_rdy           = cpu_rdy_q;
  assign dma_active        = dma_active_q;
  assign dma_address       = address_q;
  assign dma_read_n        = read_n_q;
  assign dma_write_n       = write_n_q;
  assign dma_data_out      = buffer_q;
  assign OAMDMA_reg        = page_q;
  assign OAMDMA_reg_active = 8'h00;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed/randomised bench for oam_dma_controller against a cycle-offset model of a DMA transfer.
module tb_oam_dma_controller;

  logic        cpu_clock = 1'b0;
  logic        reset;
  logic [15:0] cpu_address;
  logic        cpu_write_n;
  logic [7:0]  cpu_data_out;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_address;
  logic        dma_read_n;
  logic        dma_write_n;
  logic [7:0]  dma_data_in;
  logic [7:0]  dma_data_out;
  logic [7:0]  OAMDMA_reg;
  logic [7:0]  OAMDMA_reg_active;

  oam_dma_controller dut (
    .cpu_clock        (cpu_clock),
    .reset            (reset),
    .cpu_address      (cpu_address),
    .cpu_write_n      (cpu_write_n),
    .cpu_data_out     (cpu_data_out),
    .cpu_rdy          (cpu_rdy),
    .dma_active       (dma_active),
    .dma_address      (dma_address),
    .dma_read_n       (dma_read_n),
    .dma_write_n      (dma_write_n),
    .dma_data_in      (dma_data_in),
    .dma_data_out     (dma_data_out),
    .OAMDMA_reg       (OAMDMA_reg),
    .OAMDMA_reg_active(OAMDMA_reg_active)
  );

  always #5 cpu_clock = ~cpu_clock;

  logic [7:0] mem [0:65535];
  assign dma_data_in = mem[dma_address];

  // Parity the design should see in the current cycle.
  bit par_m = 1'b0;
  always @(posedge cpu_clock) par_m <= reset ? 1'b0 : ~par_m;

  int tests = 0;
  int fails = 0;

  task automatic step();
    @(posedge cpu_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] bus(input logic rdy, input logic act, input logic rn,
                                      input logic wn, input logic [15:0] a, input logic [7:0] d);
    return {rdy, act, rn, wn, a, d};
  endfunction

  function automatic logic [27:0] obs_bus();
    return {cpu_rdy, dma_active, dma_read_n, dma_write_n, dma_address,
            (dma_write_n ? 8'h00 : dma_data_out)};
  endfunction

  task automatic idle_inputs();
    cpu_write_n  = 1'b1;
    cpu_address  = 16'($urandom);
    cpu_data_out = 8'($urandom);
  endtask

  // halt_par: 0/1 = parity wanted in HALT, 2 = trigger in the current cycle.
  // abort_idx: index whose READ is cut by reset (-1 for none). hammer: keep writing $4014.
  task automatic run_transfer(input logic [7:0] page, input int halt_par, input int abort_idx,
                              input bit hammer);
    logic        hp;
    int          k;
    logic [15:0] a;
    if (halt_par != 2) begin
      while (par_m == halt_par[0]) step();
    end
    hp           = ~par_m;
    cpu_write_n  = 1'b0;
    cpu_address  = 16'h4014;
    cpu_data_out = page;
    step();
    if (hammer) cpu_data_out = page ^ 8'h5A;
    else idle_inputs();
    chk("halt", obs_bus(), bus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00));
    chk("oamdma_latch", {20'h0, OAMDMA_reg}, {20'h0, page});
    if (!hp) begin
      step();
      if (hammer) cpu_data_out = 8'($urandom);
      chk("align", obs_bus(), bus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00));
    end
    for (int j = 0; j < 512; j++) begin
      step();
      if (hammer) cpu_data_out = 8'($urandom);
      k = j / 2;
      a = {page, k[7:0]};
      if (j % 2 == 0) begin
        chk($sformatf("read_%04h", a), obs_bus(), bus(1'b0, 1'b1, 1'b0, 1'b1, a, 8'h00));
        if (k == abort_idx) begin
          reset = 1'b1;
          idle_inputs();
          step();
          reset = 1'b0;
          chk("abort_idle", obs_bus(), bus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00));
          chk("abort_page", {20'h0, OAMDMA_reg}, 28'h0);
          for (int n = 0; n < 4; n++) begin
            step();
            chk("abort_quiet", obs_bus(), bus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00));
          end
          return;
        end
      end else begin
        chk($sformatf("write_%04h", a), obs_bus(),
            bus(1'b0, 1'b1, 1'b1, 1'b0, 16'h2004, mem[a]));
      end
    end
    step();
    idle_inputs();
    chk("done", obs_bus(), bus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00));
    chk("oamdma_hold", {20'h0, OAMDMA_reg}, {20'h0, page});
  endtask

  initial begin
    logic [7:0] pg;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);

    reset = 1'b1;
    for (int n = 0; n < 2; n++) begin
      cpu_address  = (n == 0) ? 16'h4014 : 16'($urandom);
      cpu_write_n  = (n == 0) ? 1'b0 : 1'($urandom);
      cpu_data_out = 8'($urandom);
      step();
      chk("reset_bus", obs_bus(), bus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00));
      chk("reset_page", {20'h0, OAMDMA_reg}, 28'h0);
      chk("reset_active_reg", {20'h0, OAMDMA_reg_active}, 28'h0);
    end
    reset = 1'b0;
    idle_inputs();
    step();

    // Data = low address byte, no ALIGN.
    run_transfer(8'h02, 1, -1, 1'b0);

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // ALIGN case, with $4014 writes hammered throughout.
    pg = 8'($urandom_range(0, 254));
    run_transfer(pg, 0, -1, 1'b1);

    // Non-triggers.
    cpu_write_n  = 1'b0;
    cpu_address  = 16'h4015;
    cpu_data_out = 8'h05;
    step();
    chk("nt_4015", obs_bus(), bus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00));
    chk("nt_4015_page", {20'h0, OAMDMA_reg}, {20'h0, pg});
    cpu_write_n  = 1'b1;
    cpu_address  = 16'h4014;
    step();
    step();
    chk("nt_read", obs_bus(), bus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00));
    chk("nt_read_page", {20'h0, OAMDMA_reg}, {20'h0, pg});
    idle_inputs();
    step();

    // Abort during READ of index 100.
    run_transfer(8'($urandom_range(1, 254)), 2, 100, 1'b0);

    // Top page then back-to-back.
    run_transfer(8'hFF, 0, -1, 1'b0);
    run_transfer(8'h03, 2, -1, 1'b0);

    for (int r = 0; r < 3; r++) begin
      idle_inputs();
      for (int n = 0; n < int'($urandom_range(0, 3)); n++) step();
      run_transfer(8'($urandom), int'($urandom_range(0, 2)), -1, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
